gppcu_scoreboard: RTL

//  Issue-stage hazard scoreboard for the GPPCU core. Tracks outstanding writes per architectural register

---
 rtl/gppcu_pkg.sv | 15 +
 rtl/gppcu_sb_entry.sv | 53 +++++
 rtl/gppcu_scoreboard.sv | 111 +++++++++++
 3 files changed

// File: rtl/gppcu_pkg.sv
// Shared GPPCU definitions: register-file geometry defaults and small sizing helpers.
package gppcu_pkg;

    localparam int NUMREG_DEF  = 32;
    localparam int REGW_DEF    = $clog2(NUMREG_DEF);
    localparam int MAXPEND_DEF = 3;

    typedef logic [REGW_DEF-1:0] regIdx_t;

    // Bits needed to hold any value in 0..n (at least one bit).
    function automatic int bitsFor(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/gppcu_sb_entry.sv
// One scoreboard entry: saturating count of outstanding writes to a single register.
module gppcu_sb_entry
    import gppcu_pkg::*;
#(
    parameter int MAXPEND = MAXPEND_DEF,
    parameter int NWB     = 2,
    parameter bit BYPASS  = 1'b1,
    parameter int CNTW    = bitsFor(MAXPEND),
    parameter int DECW    = bitsFor(NWB)
) (
    input  logic            iACLK,
    input  logic            inRST,
    input  logic            iInc,
    input  logic [DECW-1:0] iDec,
    input  logic            iFlush,
    output logic [CNTW-1:0] oEffCnt,
    output logic            oBusy,
    output logic            oUnderflow
);

    // Wide enough that cnt + inc - dec never wraps before the underflow test.
    localparam int SW = CNTW + DECW + 1;

    logic [CNTW-1:0] cnt;
    logic [SW-1:0]   cntW, decW, sum, diff;

    assign cntW  = SW'(cnt);
    assign decW  = SW'(iDec);
    assign oBusy = (cnt != '0);

    // Hazard view of the count; kept free of iInc so issue never feeds back into the hazard check.
    always_comb begin
        oEffCnt = cnt;
        if (BYPASS && (decW > cntW)) oEffCnt = '0;
        else if (BYPASS)             oEffCnt = CNTW'(cntW - decW);
    end

    // Next-count arithmetic at full width; more retirements than writes in flight is an underflow.
    always_comb begin
        sum        = cntW + SW'(iInc);
        diff       = sum - decW;
        oUnderflow = (decW > sum);
    end

    // Counter update: flush wins, underflow clamps to zero, otherwise saturate at MAXPEND.
    always_ff @(posedge iACLK or negedge inRST) begin
        if (!inRST)                    cnt <= '0;
        else if (iFlush || oUnderflow) cnt <= '0;
        else if (diff > SW'(MAXPEND))  cnt <= CNTW'(MAXPEND);
        else                           cnt <= CNTW'(diff);
    end

endmodule

// File: rtl/gppcu_scoreboard.sv
// Issue-stage RAW/WAW hazard scoreboard with multi-port writeback, sticky error and stall counter.
module gppcu_scoreboard
    import gppcu_pkg::*;
#(
    parameter int NUMREG   = NUMREG_DEF,
    parameter int REGW     = $clog2(NUMREG),
    parameter int NWB      = 2,
    parameter int MAXPEND  = MAXPEND_DEF,
    parameter int ZERO_REG = 1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              iACLK,
    input  logic              inRST,
    input  logic              iVALID,
    input  logic [REGW-1:0]   iREGD,
    input  logic              iREGD_EN,
    input  logic [REGW-1:0]   iREGA,
    input  logic              iREGA_EN,
    input  logic [REGW-1:0]   iREGB,
    input  logic              iREGB_EN,
    output logic              oENABLED,
    input  logic [NWB*REGW-1:0] iWRREG,
    input  logic [NWB-1:0]    iWRREG_VALID,
    input  logic              iFLUSH,
    output logic [NUMREG-1:0] oBUSY,
    output logic              oERR,
    output logic [31:0]       oSTALL_CNT
);

    localparam int CNTW = bitsFor(MAXPEND);
    localparam int DECW = bitsFor(NWB);

    logic                          issue;
    logic                          hazA, hazB, hazD;
    logic                          wbOor;
    logic [NUMREG-1:0]             under;
    logic [NUMREG-1:0][CNTW-1:0]   effCnt;

    // An instruction presented during a flush is dropped rather than tracked.
    assign issue    = iVALID && oENABLED && !iFLUSH;
    assign oENABLED = !(hazA || hazB || hazD);

    genvar i;
    for (i = 0; i < NUMREG; i++) begin : gEnt
        logic            incI;
        logic [DECW-1:0] decI;

        // Per-register decode of the issuing destination and the writeback ports hitting it.
        always_comb begin
            incI = issue && iREGD_EN && (32'(iREGD) == i);
            decI = '0;
            for (int k = 0; k < NWB; k++)
                if (iWRREG_VALID[k] && (32'(iWRREG[k*REGW +: REGW]) == i)) decI = decI + DECW'(1);
            if (ZERO_REG != 0 && i == 0) begin
                incI = 1'b0;
                decI = '0;
            end
        end

        gppcu_sb_entry #(
            .MAXPEND (MAXPEND),
            .NWB     (NWB),
            .BYPASS  (BYPASS),
            .CNTW    (CNTW),
            .DECW    (DECW)
        ) uEntry (
            .iACLK      (iACLK),
            .inRST      (inRST),
            .iInc       (incI),
            .iDec       (decI),
            .iFlush     (iFLUSH),
            .oEffCnt    (effCnt[i]),
            .oBusy      (oBUSY[i]),
            .oUnderflow (under[i])
        );
    end

    // Hazard lookup: sources must be idle, destination must have room; out-of-range indices never match.
    always_comb begin
        hazA = 1'b0;
        hazB = 1'b0;
        hazD = 1'b0;
        for (int r = 0; r < NUMREG; r++) begin
            if (iREGA_EN && (32'(iREGA) == r) && (effCnt[r] != '0)) hazA = 1'b1;
            if (iREGB_EN && (32'(iREGB) == r) && (effCnt[r] != '0)) hazB = 1'b1;
            if (iREGD_EN && (32'(iREGD) == r) && (effCnt[r] == CNTW'(MAXPEND))) hazD = 1'b1;
        end
    end

    // Writebacks to indices beyond the register file are protocol errors.
    always_comb begin
        wbOor = 1'b0;
        for (int k = 0; k < NWB; k++)
            if (iWRREG_VALID[k] && (32'(iWRREG[k*REGW +: REGW]) >= NUMREG)) wbOor = 1'b1;
    end

    // Sticky protocol error; a flush cycle discards its writebacks without flagging them.
    always_ff @(posedge iACLK or negedge inRST) begin
        if (!inRST)                                oERR <= 1'b0;
        else if (!iFLUSH && ((|under) || wbOor))   oERR <= 1'b1;
    end

    // Saturating count of cycles where decode was held off.
    always_ff @(posedge iACLK or negedge inRST) begin
        if (!inRST)
            oSTALL_CNT <= '0;
        else if (iVALID && !oENABLED && !iFLUSH && (oSTALL_CNT != 32'hFFFF_FFFF))
            oSTALL_CNT <= oSTALL_CNT + 32'd1;
    end

endmodule
